// File: rtl/inst_queue_dual_pkg.sv
// Shared types and default sizing for the dual-push/dual-pop instruction queue.
package inst_queue_dual_pkg;

  localparam int IQ_DEPTH       = 16;
  localparam int IQ_DATA_W      = 32;
  localparam int IQ_ADDR_W      = 32;
  localparam int IQ_META_W      = 8;
  localparam int IQ_FULL_MARGIN = 2;

  // Fetch lane pattern; lane1 without lane0 is not a legal fetch group.
  typedef enum logic [1:0] {
    LANES_NONE = 2'b00,
    LANES_ONE  = 2'b01,
    LANES_BAD  = 2'b10,
    LANES_TWO  = 2'b11
  } push_lanes_e;

  function automatic logic [1:0] clamp_pop(input logic [1:0] req);
    return (req == 2'b11) ? 2'b10 : req;
  endfunction

endpackage

// File: rtl/inst_queue_dual_ram.sv
// Entry storage: two synchronous write ports and two asynchronous read ports.
module iq_ram_2w2r #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 72
) (
  input  logic                     clk,
  input  logic                     we0,
  input  logic [$clog2(DEPTH)-1:0] waddr0,
  input  logic [WIDTH-1:0]         wdata0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] waddr1,
  input  logic [WIDTH-1:0]         wdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr0,
  output logic [WIDTH-1:0]         rdata0,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output logic [WIDTH-1:0]         rdata1
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Port 1 is written last so it takes priority if both addresses ever collide.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_queue_dual.sv
// Instruction queue between fetch and issue: up to two entries in and two out per cycle,
// with exact occupancy, margin-based backpressure and a one-cycle error pulse.
module inst_queue_dual
  import inst_queue_dual_pkg::*;
#(
  parameter int DEPTH       = IQ_DEPTH,
  parameter int DATA_W      = IQ_DATA_W,
  parameter int ADDR_W      = IQ_ADDR_W,
  parameter int META_W      = IQ_META_W,
  parameter int FULL_MARGIN = IQ_FULL_MARGIN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [1:0]                 push_en_i,
  input  logic [DATA_W-1:0]          push_inst0_i,
  input  logic [DATA_W-1:0]          push_inst1_i,
  input  logic [ADDR_W-1:0]          push_pc0_i,
  input  logic [ADDR_W-1:0]          push_pc1_i,
  input  logic [META_W-1:0]          push_meta0_i,
  input  logic [META_W-1:0]          push_meta1_i,
  output logic                       push_ready_o,
  input  logic [1:0]                 pop_cnt_i,
  output logic [1:0]                 out_valid_o,
  output logic [DATA_W-1:0]          out_inst0_o,
  output logic [DATA_W-1:0]          out_inst1_o,
  output logic [ADDR_W-1:0]          out_pc0_o,
  output logic [ADDR_W-1:0]          out_pc1_o,
  output logic [META_W-1:0]          out_meta0_o,
  output logic [META_W-1:0]          out_meta1_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       err_o
);

  localparam int PW       = $clog2(DEPTH);
  localparam int CW       = PW + 1;
  localparam int EW       = DATA_W + ADDR_W + META_W;
  localparam int READY_MAX = DEPTH - 2 - FULL_MARGIN;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("inst_queue_dual: DEPTH must be a power of 2 and at least 4");
  end
  if (READY_MAX < 0 || META_W < 1) begin : g_bad_margin
    $error("inst_queue_dual: FULL_MARGIN too large for DEPTH, or META_W < 1");
  end

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          err_q;
  push_lanes_e   lanes;
  logic          push_ok, push_bad, over_pop;
  logic [1:0]    npush, npop, pop_req;
  logic [EW-1:0] rdata0, rdata1;

  assign lanes = push_lanes_e'(push_en_i);

  // Status depends only on registered occupancy, never on this cycle's inputs.
  assign push_ready_o = (count_q <= CW'(READY_MAX));
  assign out_valid_o  = {count_q >= CW'(2), count_q != '0};
  assign count_o      = count_q;
  assign err_o        = err_q;

  always_comb begin
    push_ok  = push_ready_o && (lanes == LANES_ONE || lanes == LANES_TWO);
    push_bad = (lanes == LANES_BAD) || (lanes != LANES_NONE && !push_ready_o);
    npush    = push_ok ? ((lanes == LANES_TWO) ? 2'd2 : 2'd1) : 2'd0;
    pop_req  = clamp_pop(pop_cnt_i);
    over_pop = {{(CW-2){1'b0}}, pop_req} > count_q;
    npop     = over_pop ? count_q[1:0] : pop_req;
  end

  // Flush shares the reset path: pointers and count clear, storage is left as is.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_q + PW'(npop);
      tail_q  <= tail_q + PW'(npush);
      count_q <= count_q + CW'(npush) - CW'(npop);
      err_q   <= push_bad || over_pop;
    end
  end

  iq_ram_2w2r #(
    .DEPTH(DEPTH),
    .WIDTH(EW)
  ) u_ram (
    .clk   (clk),
    .we0   (push_ok && !rst && !flush),
    .waddr0(tail_q),
    .wdata0({push_inst0_i, push_pc0_i, push_meta0_i}),
    .we1   (push_ok && push_en_i[1] && !rst && !flush),
    .waddr1(tail_q + PW'(1)),
    .wdata1({push_inst1_i, push_pc1_i, push_meta1_i}),
    .raddr0(head_q),
    .rdata0(rdata0),
    .raddr1(head_q + PW'(1)),
    .rdata1(rdata1)
  );

  assign {out_inst0_o, out_pc0_o, out_meta0_o} = rdata0;
  assign {out_inst1_o, out_pc1_o, out_meta1_o} = rdata1;

endmodule

// File: tb/tb_inst_queue_dual.sv
// Directed bench for inst_queue_dual: a queue scoreboard checked every cycle by a monitor,
// plus hand-computed checkpoints for reset, full, over-pop, flush and illegal-lane cases.
module tb_inst_queue_dual;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int META_W = 8;

  typedef struct {
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic [META_W-1:0] meta;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic [1:0]        push_en_i, pop_cnt_i;
  logic [DATA_W-1:0] push_inst0_i, push_inst1_i, out_inst0_o, out_inst1_o;
  logic [ADDR_W-1:0] push_pc0_i, push_pc1_i, out_pc0_o, out_pc1_o;
  logic [META_W-1:0] push_meta0_i, push_meta1_i, out_meta0_o, out_meta1_o;
  logic              push_ready_o, err_o;
  logic [1:0]        out_valid_o;
  logic [4:0]        count_o;

  entry_t exp_q[$];
  logic   exp_err = 1'b0;
  logic   mon_en = 1'b0;
  int     vec_cnt = 0;
  int     miss_cnt = 0;

  inst_queue_dual #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .META_W(META_W), .FULL_MARGIN(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .push_en_i(push_en_i),
    .push_inst0_i(push_inst0_i), .push_inst1_i(push_inst1_i),
    .push_pc0_i(push_pc0_i), .push_pc1_i(push_pc1_i),
    .push_meta0_i(push_meta0_i), .push_meta1_i(push_meta1_i),
    .push_ready_o(push_ready_o), .pop_cnt_i(pop_cnt_i), .out_valid_o(out_valid_o),
    .out_inst0_o(out_inst0_o), .out_inst1_o(out_inst1_o),
    .out_pc0_o(out_pc0_o), .out_pc1_o(out_pc1_o),
    .out_meta0_o(out_meta0_o), .out_meta1_o(out_meta1_o),
    .count_o(count_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference queue: follows the driven inputs at each edge using the pre-edge occupancy.
  always @(posedge clk) begin
    int     cnt, npop;
    logic [1:0] req;
    logic   any, legal, ready, over;
    if (rst || flush) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else begin
      cnt   = exp_q.size();
      ready = (cnt <= DEPTH - 4);
      any   = (push_en_i != 2'b00);
      legal = (push_en_i != 2'b10);
      req   = (pop_cnt_i == 2'b11) ? 2'b10 : pop_cnt_i;
      over  = (int'(req) > cnt);
      npop  = over ? cnt : int'(req);
      exp_err = (any && (!legal || !ready)) || over;
      for (int i = 0; i < npop; i++) void'(exp_q.pop_front());
      if (any && legal && ready) begin
        exp_q.push_back('{push_inst0_i, push_pc0_i, push_meta0_i});
        if (push_en_i[1]) exp_q.push_back('{push_inst1_i, push_pc1_i, push_meta1_i});
      end
    end
  end

  // Monitor: compares what the DUT presents against the head of the reference queue.
  always @(negedge clk) begin
    int n;
    if (mon_en) begin
      n = exp_q.size();
      cmp("mon count", 64'(count_o), 64'(n));
      cmp("mon valid", 64'(out_valid_o), {62'd0, n >= 2, n >= 1});
      cmp("mon ready", 64'(push_ready_o), 64'(n <= DEPTH - 4));
      cmp("mon err", 64'(err_o), 64'(exp_err));
      if (n >= 1) begin
        cmp("mon lane0", {out_inst0_o, out_pc0_o}, {exp_q[0].inst, exp_q[0].pc});
        cmp("mon meta0", 64'(out_meta0_o), 64'(exp_q[0].meta));
      end
      if (n >= 2) begin
        cmp("mon lane1", {out_inst1_o, out_pc1_o}, {exp_q[1].inst, exp_q[1].pc});
        cmp("mon meta1", 64'(out_meta1_o), 64'(exp_q[1].meta));
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] pen, input logic [31:0] i0, input logic [31:0] i1,
                               input logic [31:0] pc0, input logic [1:0] pop, input logic fl);
    push_en_i    = pen;
    push_inst0_i = i0;
    push_inst1_i = i1;
    push_pc0_i   = pc0;
    push_pc1_i   = pc0 + 32'd4;
    push_meta0_i = i0[7:0] ^ 8'h5A;
    push_meta1_i = i1[7:0] ^ 8'h5A;
    pop_cnt_i    = pop;
    flush        = fl;
    @(posedge clk);
    #1;
    push_en_i = 2'b00;
    pop_cnt_i = 2'b00;
    flush     = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int cnt, input logic [1:0] vld,
                             input logic rdy, input logic err);
    cmp({name, " count"}, 64'(count_o), 64'(cnt));
    cmp({name, " valid"}, 64'(out_valid_o), 64'(vld));
    cmp({name, " ready"}, 64'(push_ready_o), 64'(rdy));
    cmp({name, " err"}, 64'(err_o), 64'(err));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push_en_i = 2'b00; pop_cnt_i = 2'b00;
    push_inst0_i = '0; push_inst1_i = '0; push_pc0_i = '0; push_pc1_i = '0;
    push_meta0_i = '0; push_meta1_i = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    checkOutput("reset", 0, 2'b00, 1'b1, 1'b0);

    applyStimulus(2'b11, 32'h11, 32'h22, 32'h100, 2'd0, 1'b0);
    checkOutput("push2", 2, 2'b11, 1'b1, 1'b0);
    cmp("push2 inst0", 64'(out_inst0_o), 64'h11);
    cmp("push2 inst1", 64'(out_inst1_o), 64'h22);
    cmp("push2 pc1", 64'(out_pc1_o), 64'h104);
    applyStimulus(2'b00, 0, 0, 0, 2'd1, 1'b0);
    checkOutput("pop1", 1, 2'b01, 1'b1, 1'b0);
    cmp("pop1 inst0", 64'(out_inst0_o), 64'h22);
    applyStimulus(2'b00, 0, 0, 0, 2'd1, 1'b0);
    checkOutput("drain", 0, 2'b00, 1'b1, 1'b0);

    for (int k = 0; k < 7; k++)
      applyStimulus(2'b11, 32'h1000 + 2*k, 32'h1001 + 2*k, 32'h2000 + 8*k, 2'd0, 1'b0);
    checkOutput("fill", 14, 2'b11, 1'b0, 1'b0);
    applyStimulus(2'b11, 32'hDEAD, 32'hBEEF, 32'h3000, 2'd0, 1'b0);
    checkOutput("push full", 14, 2'b11, 1'b0, 1'b1);
    cmp("full head", 64'(out_inst0_o), 64'h1000);
    applyStimulus(2'b00, 0, 0, 0, 2'd2, 1'b0);
    checkOutput("unfull", 12, 2'b11, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++)
      applyStimulus(2'b11, 32'h5000 + 2*k, 32'h5001 + 2*k, 32'h6000 + 8*k, 2'd2, 1'b0);
    checkOutput("stream", 12, 2'b11, 1'b1, 1'b0);
    cmp("stream head0", 64'(out_inst0_o), 64'h5044);
    cmp("stream head1", 64'(out_inst1_o), 64'h5045);
    repeat (6) applyStimulus(2'b00, 0, 0, 0, 2'd2, 1'b0);
    checkOutput("stream drain", 0, 2'b00, 1'b1, 1'b0);

    applyStimulus(2'b01, 32'h77, 32'h0, 32'h700, 2'd0, 1'b0);
    applyStimulus(2'b00, 0, 0, 0, 2'd2, 1'b0);
    checkOutput("overpop", 0, 2'b00, 1'b1, 1'b1);
    applyStimulus(2'b00, 0, 0, 0, 2'd0, 1'b0);
    checkOutput("err pulse", 0, 2'b00, 1'b1, 1'b0);

    for (int k = 0; k < 4; k++)
      applyStimulus(2'b11, 32'h80 + 2*k, 32'h81 + 2*k, 32'h800 + 8*k, 2'd0, 1'b0);
    checkOutput("pre flush", 8, 2'b11, 1'b1, 1'b0);
    applyStimulus(2'b11, 32'h90, 32'h91, 32'h900, 2'd2, 1'b1);
    checkOutput("flush", 0, 2'b00, 1'b1, 1'b0);
    applyStimulus(2'b01, 32'hAA, 32'h0, 32'hA00, 2'd0, 1'b0);
    checkOutput("after flush", 1, 2'b01, 1'b1, 1'b0);
    cmp("after flush inst0", 64'(out_inst0_o), 64'hAA);

    applyStimulus(2'b10, 32'hBB, 32'hCC, 32'hB00, 2'd0, 1'b0);
    checkOutput("lane1 only", 1, 2'b01, 1'b1, 1'b1);
    cmp("lane1 only inst0", 64'(out_inst0_o), 64'hAA);
    applyStimulus(2'b01, 32'hDD, 32'h0, 32'hD00, 2'd0, 1'b0);
    applyStimulus(2'b00, 0, 0, 0, 2'd3, 1'b0);
    checkOutput("pop3 clamp", 0, 2'b00, 1'b1, 1'b0);

    for (int k = 0; k < 6; k++)
      applyStimulus(2'b11, 32'hE0 + 2*k, 32'hE1 + 2*k, 32'hE00 + 8*k, 2'd0, 1'b0);
    checkOutput("edge 12", 12, 2'b11, 1'b1, 1'b0);
    applyStimulus(2'b01, 32'hF0, 32'h0, 32'hF00, 2'd0, 1'b0);
    checkOutput("edge 13", 13, 2'b11, 1'b0, 1'b0);
    applyStimulus(2'b01, 32'hF1, 32'h0, 32'hF10, 2'd1, 1'b0);
    checkOutput("edge drop", 12, 2'b11, 1'b1, 1'b1);
    applyStimulus(2'b00, 0, 0, 0, 2'd0, 1'b1);
    checkOutput("final flush", 0, 2'b00, 1'b1, 1'b0);

    repeat (2) applyStimulus(2'b00, 0, 0, 0, 2'd0, 1'b0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
